// File: rtl/frame_writer.sv
// -----------------------------------------------------------------------------
// frame_writer
//
// Packs an 8-bit palette-index pixel stream into 128-bit words (16 pixels per
// word, first pixel in the low byte) and writes them to the SDRAM back buffer.
// The back buffer is the one the display is not reading: frame_flip=1 selects
// 0x200000, frame_flip=0 selects 0x100000. A frame is LINES x 40 words.
//
// Optional feature: when the macro FRAME_CLEAR_EN is defined, the port
// clear_index is added and every frame starts by filling the whole back buffer
// with clear_index replicated 16 times before pixels are accepted.
//
// Ports
//   clock        in   1    system clock, rising edge
//   reset        in   1    synchronous active-high reset
//   new_frame    in   1    frame-start pulse (restarts the writer from any state)
//   frame_flip   in   1    display buffer select, latched at new_frame
//   pix_valid    in   1    upstream pixel strobe
//   pix_data     in   8    palette index
//   pix_ready    out  1    pixel accepted when pix_valid && pix_ready
//   disp_busy    in   1    display line buffer owns the SDRAM
//   sdram_Wait   in   1    SDRAM not yet initialised
//   sdram_wr     out  1    write request, held until sdram_ac
//   sdram_ac     in   1    one-cycle write acknowledge
//   sdram_addr   out  22   word address (base + word counter)
//   sdram_wdata  out  128  packed write word
//   done         out  1    back buffer fully written
//   clear_index  in   8    clear colour (FRAME_CLEAR_EN builds only)
// -----------------------------------------------------------------------------
module frame_writer #(
    parameter int unsigned LINES = 480
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         new_frame,
    input  logic         frame_flip,
    input  logic         pix_valid,
    input  logic [7:0]   pix_data,
    output logic         pix_ready,
    input  logic         disp_busy,
    input  logic         sdram_Wait,
    output logic         sdram_wr,
    input  logic         sdram_ac,
    output logic [21:0]  sdram_addr,
    output logic [127:0] sdram_wdata,
`ifdef FRAME_CLEAR_EN
    input  logic [7:0]   clear_index,
`endif
    output logic         done
);

    localparam int unsigned WORDS_PER_LINE = 40;
    localparam int unsigned FRAME_WORDS    = LINES * WORDS_PER_LINE;
    localparam logic [14:0] LAST_WORD      = 15'(FRAME_WORDS - 1);
    localparam logic [21:0] BASE_LOW       = 22'h100000;
    localparam logic [21:0] BASE_HIGH      = 22'h200000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
`ifdef FRAME_CLEAR_EN
        CLEAR = 3'd1,
`endif
        FILL  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t         r_state;
    logic [21:0]    r_base;
    logic [14:0]    r_word_cnt;
    logic [3:0]     r_pix_cnt;
    logic [127:0]   r_wdata;
    logic           r_wr;
    logic           r_pix_ready;
    logic           r_done;

    logic           w_accept;
    logic           w_ack;
    logic           w_can_req;
    logic           w_last_word;
    logic [21:0]    w_new_base;

    assign w_accept    = pix_valid & r_pix_ready;
    // An acknowledge only means something while our request is pending.
    assign w_ack       = sdram_ac & r_wr;
    assign w_can_req   = ~disp_busy & ~sdram_Wait;
    assign w_last_word = (r_word_cnt == LAST_WORD);
    // Write into the buffer the display is not reading.
    assign w_new_base  = frame_flip ? BASE_HIGH : BASE_LOW;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_base      <= BASE_LOW;
            r_word_cnt  <= '0;
            r_pix_cnt   <= '0;
            r_wdata     <= '0;
            r_wr        <= 1'b0;
            r_pix_ready <= 1'b0;
            r_done      <= 1'b0;
        end else if (new_frame) begin
            // Restart wins over any handshake in flight; an acked write in
            // this cycle is deliberately lost.
            r_base      <= w_new_base;
            r_word_cnt  <= '0;
            r_pix_cnt   <= '0;
            r_wr        <= 1'b0;
            r_done      <= 1'b0;
`ifdef FRAME_CLEAR_EN
            r_state     <= CLEAR;
            r_pix_ready <= 1'b0;
            r_wdata     <= {16{clear_index}};
`else
            r_state     <= FILL;
            r_pix_ready <= 1'b1;
            r_wdata     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_wr        <= 1'b0;
                    r_pix_ready <= 1'b0;
                end

`ifdef FRAME_CLEAR_EN
                CLEAR: begin
                    if (!r_wr) begin
                        if (w_can_req) begin
                            r_wr <= 1'b1;
                        end
                    end else if (w_ack) begin
                        r_wr <= 1'b0;
                        if (w_last_word) begin
                            r_word_cnt  <= '0;
                            r_pix_cnt   <= '0;
                            r_state     <= FILL;
                            r_pix_ready <= 1'b1;
                        end else begin
                            r_word_cnt <= r_word_cnt + 15'd1;
                        end
                    end
                end
`endif

                FILL: begin
                    if (w_accept) begin
                        r_wdata[{r_pix_cnt, 3'b000} +: 8] <= pix_data;
                        // The 4-bit counter wraps to 0 on the 16th pixel,
                        // ready for the next word.
                        r_pix_cnt <= r_pix_cnt + 4'd1;
                        if (r_pix_cnt == 4'd15) begin
                            r_state     <= WRITE;
                            r_pix_ready <= 1'b0;
                        end
                    end
                end

                WRITE: begin
                    // Once raised, the request is held with stable address and
                    // data until acknowledged, even if disp_busy rises.
                    if (!r_wr) begin
                        if (w_can_req) begin
                            r_wr <= 1'b1;
                        end
                    end else if (w_ack) begin
                        r_wr <= 1'b0;
                        if (w_last_word) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_word_cnt  <= r_word_cnt + 15'd1;
                            r_state     <= FILL;
                            r_pix_ready <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    r_wr        <= 1'b0;
                    r_pix_ready <= 1'b0;
                    r_done      <= 1'b1;
                end

                default: begin
                    r_state     <= IDLE;
                    r_wr        <= 1'b0;
                    r_pix_ready <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign pix_ready   = r_pix_ready;
    assign sdram_wr    = r_wr;
    assign sdram_addr  = r_base + 22'(r_word_cnt);
    assign sdram_wdata = r_wdata;
    assign done        = r_done;

endmodule

// File: tb/tb_frame_writer.sv
module tb_frame_writer;

    // Reduced frame height keeps full-frame runs short; the address and
    // packing rules are the same as for the full 480-line frame.
    localparam int unsigned LINES       = 2;
    localparam int unsigned FRAME_WORDS = LINES * 40;
    localparam int          LIMIT       = 300;

    logic         clock = 1'b0;
    logic         reset;
    logic         new_frame;
    logic         frame_flip;
    logic         pix_valid;
    logic [7:0]   pix_data;
    logic         pix_ready;
    logic         disp_busy;
    logic         sdram_Wait;
    logic         sdram_wr;
    logic         sdram_ac;
    logic [21:0]  sdram_addr;
    logic [127:0] sdram_wdata;
    logic         done;
    logic [7:0]   ci;

    int checks = 0;
    int errors = 0;

    logic [7:0] pw [16];

    always #5 clock = ~clock;

    frame_writer #(.LINES(LINES)) dut (
        .clock       (clock),
        .reset       (reset),
        .new_frame   (new_frame),
        .frame_flip  (frame_flip),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .disp_busy   (disp_busy),
        .sdram_Wait  (sdram_Wait),
        .sdram_wr    (sdram_wr),
        .sdram_ac    (sdram_ac),
        .sdram_addr  (sdram_addr),
        .sdram_wdata (sdram_wdata),
`ifdef FRAME_CLEAR_EN
        .clear_index (ci),
`endif
        .done        (done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk22(input string tag, input logic [21:0] obs, input logic [21:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference word: pixel i of the word occupies byte i.
    function automatic logic [127:0] packw();
        logic [127:0] d;
        d = '0;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = pw[i];
        return d;
    endfunction

    task automatic rand_word();
        for (int i = 0; i < 16; i++) pw[i] = 8'($urandom);
    endtask

    task automatic send_pix(input logic [7:0] p);
        int n;
        n = 0;
        pix_valid = 1'b1;
        pix_data  = p;
        while (pix_ready !== 1'b1 && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) chk1("pix_ready_timeout", 1'b1, 1'b0);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic send_word();
        for (int i = 0; i < 16; i++) send_pix(pw[i]);
    endtask

    task automatic wait_wr(input string tag);
        int n;
        n = 0;
        while (sdram_wr !== 1'b1 && n < LIMIT) begin
            tick();
            n++;
        end
        chk1({tag, "_wr_timeout"}, 1'(n >= LIMIT), 1'b0);
    endtask

    task automatic expect_write(input string tag, input logic [21:0] ea, input logic [127:0] ed,
                                input int hold, input logic busy_hold);
        int bad;
        bad = 0;
        wait_wr(tag);
        chk22({tag, "_addr"}, sdram_addr, ea);
        chk128({tag, "_data"}, sdram_wdata, ed);
        chk1({tag, "_done"}, done, 1'b0);
        disp_busy = busy_hold;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (sdram_wr !== 1'b1 || sdram_addr !== ea || sdram_wdata !== ed) bad++;
        end
        chkn({tag, "_hold"}, bad, 0);
        sdram_ac = 1'b1;
        tick();
        sdram_ac  = 1'b0;
        disp_busy = 1'b0;
        chk1({tag, "_drop"}, sdram_wr, 1'b0);
    endtask

    task automatic pulse_nf(input logic flip);
        frame_flip = flip;
        new_frame  = 1'b1;
        tick();
        new_frame  = 1'b0;
    endtask

    task automatic after_nf(input string tag, input logic [21:0] base);
        int pr;
        pr = 0;
        chk1({tag, "_nf_wr"}, sdram_wr, 1'b0);
        chk1({tag, "_nf_done"}, done, 1'b0);
`ifdef FRAME_CLEAR_EN
        for (int k = 0; k < int'(FRAME_WORDS); k++) begin
            if (pix_ready !== 1'b0) pr++;
            expect_write({tag, "_clr"}, base + 22'(k), {16{ci}}, 0, 1'b0);
        end
        chkn({tag, "_clr_ready_low"}, pr, 0);
`endif
        chk1({tag, "_nf_ready"}, pix_ready, 1'b1);
    endtask

    task automatic run_words(input string tag, input logic [21:0] base, input int from, input int upto);
        for (int w = from; w < upto; w++) begin
            rand_word();
            send_word();
            expect_write(tag, base + 22'(w), packw(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        int bad;
        reset      = 1'b1;
        new_frame  = 1'b1;
        frame_flip = 1'b1;
        pix_valid  = 1'b0;
        pix_data   = '0;
        disp_busy  = 1'b0;
        sdram_Wait = 1'b0;
        sdram_ac   = 1'b0;
        ci         = 8'h2A;

        // Reset overrides a simultaneous new_frame.
        tick();
        tick();
        new_frame = 1'b0;
        reset     = 1'b0;
        chk1("rst_wr", sdram_wr, 1'b0);
        chk1("rst_ready", pix_ready, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk22("rst_addr", sdram_addr, 22'h100000);
        chk128("rst_wdata", sdram_wdata, '0);

        // IDLE is left only by new_frame.
        bad = 0;
        pix_valid = 1'b1;
        sdram_ac  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pix_ready !== 1'b0 || sdram_wr !== 1'b0) bad++;
        end
        pix_valid = 1'b0;
        sdram_ac  = 1'b0;
        chkn("idle_hold", bad, 0);
        chk22("idle_addr", sdram_addr, 22'h100000);

        // Frame A, flip=1: directed first word 0x00..0x0F.
        pulse_nf(1'b1);
        after_nf("A", 22'h200000);
        for (int i = 0; i < 16; i++) pw[i] = 8'(i);
        send_word();
        chk1("w0_ready_low", pix_ready, 1'b0);
        chk1("w0_wr_not_yet", sdram_wr, 1'b0);
        expect_write("w0", 22'h200000, 128'h0F0E0D0C0B0A09080706050403020100, 0, 1'b0);

        // Stray acknowledge with no request pending must be ignored.
        sdram_ac = 1'b1;
        tick();
        sdram_ac = 1'b0;
        chk1("stray_ac_wr", sdram_wr, 1'b0);

        // disp_busy / sdram_Wait block the request; busy after raise does not.
        rand_word();
        for (int i = 0; i < 15; i++) send_pix(pw[i]);
        disp_busy = 1'b1;
        send_pix(pw[15]);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (sdram_wr !== 1'b0 || pix_ready !== 1'b0) bad++;
        end
        chkn("busy_block", bad, 0);
        disp_busy  = 1'b0;
        sdram_Wait = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sdram_wr !== 1'b0) bad++;
        end
        chkn("wait_block", bad, 0);
        sdram_Wait = 1'b0;
        expect_write("w1", 22'h200001, packw(), 12, 1'b1);

        run_words("A", 22'h200000, 2, int'(FRAME_WORDS));
        chk1("A_done", done, 1'b1);
        chk1("A_done_ready", pix_ready, 1'b0);
        chk1("A_done_wr", sdram_wr, 1'b0);
        bad = 0;
        pix_valid = 1'b1;
        sdram_ac  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pix_ready !== 1'b0 || sdram_wr !== 1'b0 || done !== 1'b1) bad++;
        end
        pix_valid = 1'b0;
        sdram_ac  = 1'b0;
        chkn("A_done_hold", bad, 0);

        // Frame B, flip=0: full frame ending at base + FRAME_WORDS - 1.
        ci = 8'($urandom);
        pulse_nf(1'b0);
        after_nf("B", 22'h100000);
        run_words("B", 22'h100000, 0, int'(FRAME_WORDS));
        chk1("B_done", done, 1'b1);
        chk1("B_done_ready", pix_ready, 1'b0);
        chk1("B_done_wr", sdram_wr, 1'b0);

        // new_frame mid-word (7 pixels into word 41) with a pixel offered.
        ci = 8'($urandom);
        pulse_nf(1'b1);
        after_nf("C", 22'h200000);
        run_words("C", 22'h200000, 0, 41);
        rand_word();
        for (int i = 0; i < 7; i++) send_pix(pw[i]);
        ci         = 8'($urandom);
        frame_flip = 1'b0;
        new_frame  = 1'b1;
        pix_valid  = 1'b1;
        pix_data   = 8'hEE;
        tick();
        new_frame  = 1'b0;
        pix_valid  = 1'b0;
        after_nf("C2", 22'h100000);
        rand_word();
        send_word();
        expect_write("C2w0", 22'h100000, packw(), 0, 1'b0);

        // new_frame in the same cycle as sdram_ac.
        run_words("D", 22'h100000, 1, 2);
        rand_word();
        send_word();
        wait_wr("D_pend");
        ci         = 8'($urandom);
        frame_flip = 1'b1;
        new_frame  = 1'b1;
        sdram_ac   = 1'b1;
        tick();
        new_frame  = 1'b0;
        sdram_ac   = 1'b0;
        chk1("D_nf_ac_wr", sdram_wr, 1'b0);
        chk22("D_nf_ac_addr", sdram_addr, 22'h200000);
        after_nf("D2", 22'h200000);
        rand_word();
        send_word();
        expect_write("D2w0", 22'h200000, packw(), 1, 1'b0);

        // Reset with a pending request and a simultaneous acknowledge.
        rand_word();
        send_word();
        wait_wr("E_pend");
        reset    = 1'b1;
        sdram_ac = 1'b1;
        tick();
        reset    = 1'b0;
        sdram_ac = 1'b0;
        chk1("E_rst_wr", sdram_wr, 1'b0);
        chk1("E_rst_ready", pix_ready, 1'b0);
        chk1("E_rst_done", done, 1'b0);
        chk22("E_rst_addr", sdram_addr, 22'h100000);
        chk128("E_rst_wdata", sdram_wdata, '0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (sdram_wr !== 1'b0 || pix_ready !== 1'b0) bad++;
        end
        chkn("E_idle_hold", bad, 0);

        ci = 8'($urandom);
        pulse_nf(1'b0);
        after_nf("F", 22'h100000);
        rand_word();
        send_word();
        expect_write("Fw0", 22'h100000, packw(), 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
